data_mem_ctrl: RTL and testbench

Word-addressed data-memory controller sitting directly downstream of the MIPS core's load/store path, replacing the zero-latency combinational data memory. It accepts one load or store per request over a req/ready handshake, inserts a parameterised number of wait states, and supports byte-lane writes. Optional misalignment checking flags non-word-aligned accesses back to the core.

---
 rtl/data_mem_ctrl_pkg.sv | 12 +
 rtl/data_mem_ctrl_if.sv | 24 ++
 rtl/data_mem_ctrl_sram.sv | 41 ++++
 rtl/data_mem_ctrl.sv | 116 +++++++++++
 tb/tb_data_mem_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller slice.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LANE_BITS  = 8;
  localparam logic [WORD_BYTES-1:0] BE_ALL = '1;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side load/store bus between the MIPS core (master) and the data-memory controller (slave).
interface data_mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                  req;
  logic                  we;
  logic [31:0]           adr;
  logic [31:0]           wdata;
  logic [WORD_BYTES-1:0] byte_en;
  logic [31:0]           rdata;
  logic                  ready;
  logic                  busy;
  logic                  err;

  modport master (
    output req, we, adr, wdata, byte_en,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, adr, wdata, byte_en,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/data_mem_ctrl_sram.sv
// Single-port DEPTH_WORDS x 32 memory, one byte-wide array per lane, registered read.
module sram_1p
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [LANE_BITS-1:0] mem [0:DEPTH_WORDS-1];
      logic [LANE_BITS-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (en && we && be[gi]) begin
          mem[addr] <= wdata[gi*LANE_BITS +: LANE_BITS];
        end
      end

      // Read register only moves on loads so it doubles as the held rdata.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q_reg <= '0;
        end else if (en && !we) begin
          q_reg <= mem[addr];
        end
      end

      assign rdata[gi*LANE_BITS +: LANE_BITS] = q_reg;
    end
  endgenerate
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: req/ready handshake, WAIT_STATES wait cycles, byte-lane stores.
// Optional MISALIGN_CHK_EN: flag non-word-aligned accesses with err and suppress them.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic                    we_reg;
  logic [ADDR_BITS+1:0]    adr_reg;
  logic [31:0]             wdata_reg;
  logic [WORD_BYTES-1:0]   be_reg;
  logic                    ready_reg;
  logic                    busy_reg;
  logic                    err_reg;

  logic                    access;
  logic                    misalign;
  logic                    mem_en;
  logic [31:0]             mem_rdata;

  // Upper address bits alias onto the array.
  logic unused_adr_hi;
  assign unused_adr_hi = ^bus.adr[31:ADDR_BITS+2];

`ifdef MISALIGN_CHK_EN
  assign misalign = (adr_reg[1:0] != 2'b00);
`else
  logic unused_adr_lo;
  assign unused_adr_lo = ^adr_reg[1:0];
  assign misalign = 1'b0;
`endif

  assign access = (state_reg == WAIT) && (cnt_reg == 4'd0);
  assign mem_en = access && !misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      adr_reg   <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          if (bus.req) begin
            we_reg    <= bus.we;
            adr_reg   <= bus.adr[ADDR_BITS+1:0];
            wdata_reg <= bus.wdata;
            be_reg    <= bus.byte_en;
            cnt_reg   <= WS_INIT;
            busy_reg  <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            // The array access happens on this same edge via mem_en.
            ready_reg <= 1'b1;
            err_reg   <= misalign;
            state_reg <= ACK;
          end
        end
        ACK: begin
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  sram_1p #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_BITS  (ADDR_BITS)
  ) u_sram (
    .clk  (clk),
    .rst  (rst),
    .en   (mem_en),
    .we   (we_reg),
    .be   (be_reg),
    .addr (adr_reg[ADDR_BITS+1:2]),
    .wdata(wdata_reg),
    .rdata(mem_rdata)
  );

  assign bus.rdata = mem_rdata;
  assign bus.ready = ready_reg;
  assign bus.busy  = busy_reg;
  assign bus.err   = err_reg;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: latency, byte lanes, wrap, reset abort, handshake corner cases.
module tb_data_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int WS    = 2;
  localparam int DEPTH = 1024;
  localparam int LAT   = WS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  data_mem_ctrl_if bus();

  data_mem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One complete transaction from IDLE; checks latency, err, rdata at ready, return to IDLE.
  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.adr = a; bus.wdata = d; bus.byte_en = be;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(LAT));
    check({tag, ".err"}, 32'(bus.err), 32'(exp_err));
    check({tag, ".rdata"}, bus.rdata, exp_rdata);
    $display("xact %s we=%0b adr=%08h wdata=%08h be=%04b lat=%0d rdata=%08h err=%0b",
             tag, w, a, d, be, lat, bus.rdata, bus.err);
    @(posedge clk); #1;
    check({tag, ".idle"}, 32'({bus.busy, bus.ready}), 32'd0);
  endtask

  int n_rdy;
  int r1, r2;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.wdata = '0; bus.byte_en = '0;

    // Asynchronous reset at time zero, outputs checked without a clock edge.
    #1 rst = 1'b0;
    #1;
    check("rst.ready", 32'(bus.ready), 32'd0);
    check("rst.busy",  32'(bus.busy),  32'd0);
    check("rst.err",   32'(bus.err),   32'd0);
    check("rst.rdata", bus.rdata, 32'h0000_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    xact("st10",    1'b1, 32'h10, 32'hDEADBEEF, BE_ALL,  32'h0000_0000, 1'b0);
    xact("ld10",    1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);
    xact("st10_lo", 1'b1, 32'h10, 32'h12345678, 4'b0011, 32'hDEADBEEF, 1'b0);
    xact("ld10_b",  1'b0, 32'h10, 32'h0,        BE_ALL,  32'hDEAD5678, 1'b0);
    xact("st10_no", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'hDEAD5678, 1'b0);
    xact("ld10_c",  1'b0, 32'h10, 32'h0,        BE_ALL,  32'hDEAD5678, 1'b0);
    xact("st14",    1'b1, 32'h14, 32'h0BADF00D, BE_ALL,  32'hDEAD5678, 1'b0);
    xact("ld14",    1'b0, 32'h14, 32'h0,        BE_ALL,  32'h0BADF00D, 1'b0);
`ifdef MISALIGN_CHK_EN
    xact("ld13",    1'b0, 32'h13, 32'h0,        BE_ALL,  32'h0BADF00D, 1'b1);
    xact("st11",    1'b1, 32'h11, 32'hFFFFFFFF, BE_ALL,  32'h0BADF00D, 1'b1);
    xact("ld10_d",  1'b0, 32'h10, 32'h0,        BE_ALL,  32'hDEAD5678, 1'b0);
`else
    xact("ld13",    1'b0, 32'h13, 32'h0,        BE_ALL,  32'hDEAD5678, 1'b0);
`endif

    // Address 0x1000 is word 1024, which wraps onto word 0.
    xact("st_wrap", 1'b1, 32'h1000, 32'hCAFEF00D, BE_ALL,  32'hDEAD5678, 1'b0);
    xact("ld_wrap", 1'b0, 32'h0,    32'h0,        BE_ALL,  32'hCAFEF00D, 1'b0);
    xact("st_l3",   1'b1, 32'h0,    32'hAB000000, 4'b1000, 32'hCAFEF00D, 1'b0);
    xact("ld_l3",   1'b0, 32'h0,    32'h0,        BE_ALL,  32'hABFEF00D, 1'b0);
    xact("st20",    1'b1, 32'h20,   32'hA5A5A5A5, BE_ALL,  32'hABFEF00D, 1'b0);

    // Reset asserted while a store is waiting: store must be dropped.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.adr = 32'h20; bus.wdata = 32'h11111111; bus.byte_en = BE_ALL;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("abort.busy_pre", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("abort.busy",  32'(bus.busy),  32'd0);
    check("abort.ready", 32'(bus.ready), 32'd0);
    check("abort.err",   32'(bus.err),   32'd0);
    check("abort.rdata", bus.rdata, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) n_rdy++;
    end
    check("abort.no_ready", 32'(n_rdy), 32'd0);
    $display("xact abort st20 wdata=11111111 dropped ready_count=%0d", n_rdy);
    xact("ld20", 1'b0, 32'h20, 32'h0, BE_ALL, 32'hA5A5A5A5, 1'b0);

    // A req pulse during WAIT must not queue a second transaction.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.adr = 32'h10; bus.byte_en = BE_ALL;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    n_rdy = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) n_rdy++;
    end
    check("pulse.ready_cnt", 32'(n_rdy), 32'd1);
    check("pulse.rdata", bus.rdata, 32'hDEAD5678);
    $display("xact pulse ld10 ready_count=%0d rdata=%08h", n_rdy, bus.rdata);

    // req held high: back-to-back accepts every WS+3 cycles.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.adr = 32'h0; bus.byte_en = BE_ALL;
    r1 = -1;
    r2 = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
    end
    check("b2b.first", 32'(r1), 32'(LAT));
    check("b2b.gap", 32'(r2 - r1), 32'(WS + 3));
    check("b2b.rdata", bus.rdata, 32'hABFEF00D);
    $display("xact b2b ld0 ready_at=%0d,%0d rdata=%08h", r1, r2, bus.rdata);
    @(negedge clk);
    bus.req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b0) break;
    end
    check("b2b.drained", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
